// File: rtl/jtag_tap_ctrl_if.sv
// TAP-side bundle: TMS/TDI/selected data register in, TDO and shift/instruction state out.
interface jtag_tap_ctrl_if #(
  parameter int REG_W = 32
);
  logic             tms;
  logic             tdi;
  logic [REG_W-1:0] data_reg;
  logic             tdo;
  logic             tdo_en;
  logic [REG_W-1:0] shift_reg;
  logic [REG_W-1:0] instr_reg;
  logic             state_is_update_dr;
  logic [3:0]       state;

  // master drives the scan pins, slave is the TAP controller
  modport master (
    output tms, tdi, data_reg,
    input  tdo, tdo_en, shift_reg, instr_reg, state_is_update_dr, state
  );
  modport slave (
    input  tms, tdi, data_reg,
    output tdo, tdo_en, shift_reg, instr_reg, state_is_update_dr, state
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP state machine with DR/IR shift stages and instruction register.
// Macro JTAG_TDO_NEGEDGE_EN: retime TDO and TDO-enable onto the falling edge of TCK.
module jtag_tap_ctrl #(
  parameter int               REG_W  = 32,
  parameter logic [REG_W-1:0] IR_RST = REG_W'(1)  // IDCODE opcode
) (
  input logic            i_tclk,
  input logic            i_trst_n,
  jtag_tap_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_e;

  tap_state_e       state;
  logic [REG_W-1:0] shift_reg;
  logic [REG_W-1:0] ir_shift;
  logic [REG_W-1:0] instr_reg;
  logic             tdo_src;
  logic             tdo_en_src;

  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    case (s)
      TLR:      return tms ? TLR      : RTI;
      RTI:      return tms ? SEL_DR   : RTI;
      SEL_DR:   return tms ? SEL_IR   : CAP_DR;
      CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return tms ? SEL_DR   : RTI;
      SEL_IR:   return tms ? TLR      : CAP_IR;
      CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   return tms ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction

  // register actions are keyed on the state being left, so a capture lands on the exit edge
  always_ff @(posedge i_tclk or negedge i_trst_n) begin
    if (!i_trst_n) begin
      state     <= TLR;
      shift_reg <= '0;
      ir_shift  <= '0;
      instr_reg <= IR_RST;
    end else begin
      state <= next_state(state, bus.tms);
      case (state)
        CAP_DR:   shift_reg <= bus.data_reg;
        SHIFT_DR: shift_reg <= {bus.tdi, shift_reg[REG_W-1:1]};
        CAP_IR:   ir_shift  <= REG_W'(1);
        SHIFT_IR: ir_shift  <= {bus.tdi, ir_shift[REG_W-1:1]};
        UPD_IR:   instr_reg <= ir_shift;
        TLR:      instr_reg <= IR_RST;
        default:  ;
      endcase
    end
  end

  always_comb begin
    tdo_en_src = (state == SHIFT_DR) || (state == SHIFT_IR);
    tdo_src    = 1'b0;
    if (state == SHIFT_DR)      tdo_src = shift_reg[0];
    else if (state == SHIFT_IR) tdo_src = ir_shift[0];
  end

`ifdef JTAG_TDO_NEGEDGE_EN
  logic tdo_q;
  logic tdo_en_q;

  always_ff @(negedge i_tclk or negedge i_trst_n) begin
    if (!i_trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_src;
      tdo_en_q <= tdo_en_src;
    end
  end

  assign bus.tdo    = tdo_q;
  assign bus.tdo_en = tdo_en_q;
`else
  assign bus.tdo    = tdo_src;
  assign bus.tdo_en = tdo_en_src;
`endif

  assign bus.shift_reg          = shift_reg;
  assign bus.instr_reg          = instr_reg;
  assign bus.state_is_update_dr = (state == UPD_DR);
  assign bus.state              = state;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomised and directed bench for jtag_tap_ctrl against a table-driven TAP model.
module tb_jtag_tap_ctrl;
  localparam logic [31:0] IR_RST_T = 32'hC0DE_0011;

  // next-state tables indexed by state code: TMS=0 and TMS=1
  localparam logic [3:0] NX0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                      4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  localparam logic [3:0] NX1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                      4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  logic i_tclk;
  logic i_trst_n;
  logic clk_run;
  jtag_tap_ctrl_if #(.REG_W(32)) bus ();

  jtag_tap_ctrl #(.REG_W(32), .IR_RST(IR_RST_T)) dut (
    .i_tclk  (i_tclk),
    .i_trst_n(i_trst_n),
    .bus     (bus.slave)
  );

  initial begin
    i_tclk = 1'b0;
    forever begin
      #5;
      if (clk_run) i_tclk = ~i_tclk;
    end
  end

  int checks   = 0;
  int failures = 0;
  int upd_hi   = 0;
  bit chk_en   = 1'b0;

  logic [3:0]  m_state;
  logic [31:0] m_sh, m_ir, m_instr;
  logic        m_src_prev, m_en_prev;
  logic        s_tdo;
  logic [31:0] s_sr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_src(input logic [3:0] st, input logic [31:0] sh, input logic [31:0] ir);
    if (st == 4'h2) return sh[0];
    if (st == 4'hA) return ir[0];
    return 1'b0;
  endfunction

  function automatic logic exp_en(input logic [3:0] st);
    return (st == 4'h2) || (st == 4'hA);
  endfunction

  // reference model
  always @(posedge i_tclk or negedge i_trst_n) begin
    if (!i_trst_n) begin
      m_state    <= 4'hF;
      m_sh       <= '0;
      m_ir       <= '0;
      m_instr    <= IR_RST_T;
      m_src_prev <= 1'b0;
      m_en_prev  <= 1'b0;
    end else begin
      m_src_prev <= exp_src(m_state, m_sh, m_ir);
      m_en_prev  <= exp_en(m_state);
      m_state    <= bus.tms ? NX1[m_state] : NX0[m_state];
      if (m_state == 4'h6) m_sh    <= bus.data_reg;
      if (m_state == 4'h2) m_sh    <= (m_sh >> 1) | (32'(bus.tdi) << 31);
      if (m_state == 4'hE) m_ir    <= 32'd1;
      if (m_state == 4'hA) m_ir    <= (m_ir >> 1) | (32'(bus.tdi) << 31);
      if (m_state == 4'hD) m_instr <= m_ir;
      if (m_state == 4'hF) m_instr <= IR_RST_T;
    end
  end

  // per-cycle compare, mid-low phase
  always @(negedge i_tclk) begin
    #1;
    if (chk_en && i_trst_n) begin
      chk("state",     32'(bus.state),              32'(m_state));
      chk("shift_reg", bus.shift_reg,               m_sh);
      chk("instr_reg", bus.instr_reg,               m_instr);
      chk("upd_dr",    32'(bus.state_is_update_dr), 32'(m_state == 4'h5));
      chk("tdo_en",    32'(bus.tdo_en),             32'(exp_en(m_state)));
      chk("tdo",       32'(bus.tdo),                32'(exp_src(m_state, m_sh, m_ir)));
      if (bus.state_is_update_dr) upd_hi++;
    end
  end

  // just after the rising edge: registered TDO still shows the old bit, combinational TDO the new one
  always @(posedge i_tclk) begin
    #1;
    if (chk_en && i_trst_n) begin
`ifdef JTAG_TDO_NEGEDGE_EN
      chk("tdo_post_pos",    32'(bus.tdo),    32'(m_src_prev));
      chk("tdo_en_post_pos", 32'(bus.tdo_en), 32'(m_en_prev));
`else
      chk("tdo_post_pos",    32'(bus.tdo),    32'(exp_src(m_state, m_sh, m_ir)));
      chk("tdo_en_post_pos", 32'(bus.tdo_en), 32'(exp_en(m_state)));
`endif
    end
  end

  task automatic tick(input logic tms, input logic tdi);
    bus.tms = tms;
    bus.tdi = tdi;
    #1;
    s_tdo = bus.tdo;
    s_sr  = bus.shift_reg;
    @(negedge i_tclk);
  endtask

  // park the clock low, pulse TRST and check the reset values with no edge present
  task automatic hard_reset();
    clk_run = 1'b0;
    #12;
    i_trst_n = 1'b0;
    #2;
    chk("rst_state",  32'(bus.state),              32'hF);
    chk("rst_instr",  bus.instr_reg,               IR_RST_T);
    chk("rst_shift",  bus.shift_reg,               32'h0);
    chk("rst_tdo",    32'(bus.tdo),                32'h0);
    chk("rst_tdo_en", 32'(bus.tdo_en),             32'h0);
    chk("rst_upd",    32'(bus.state_is_update_dr), 32'h0);
    bus.tms = 1'b1;
    bus.tdi = 1'b0;
    #2 i_trst_n = 1'b1;
    #2 clk_run = 1'b1;
    @(negedge i_tclk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w, dat, tdiw, p0;
    bit          hit;
    clk_run      = 1'b0;
    i_trst_n     = 1'b1;
    bus.tms      = 1'b1;
    bus.tdi      = 1'b0;
    bus.data_reg = '0;
    #1;
    hard_reset();
    chk_en = 1'b1;

    // reset in the middle of a DR scan
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) tick(0, 1);
    chk("in_shift_dr", 32'(bus.state), 32'h2);
    hard_reset();

    // reset while Update-DR is asserted
    tick(0, 0); tick(1, 0); tick(0, 0); tick(1, 0); tick(1, 0);
    #1 chk("upd_before_rst", 32'(bus.state_is_update_dr), 32'h1);
    hard_reset();

    // IR load of 0x3
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    w = '0;
    for (int i = 0; i < 32; i++) begin
      tick(i == 31, (i < 2));
      w[i] = s_tdo;
    end
    chk("ir_tdo_stream", w, 32'h0000_0001);
    tick(1, 0);
    #1 chk("instr_in_upd_ir", bus.instr_reg, IR_RST_T);
    tick(0, 0);
    #1 chk("instr_loaded", bus.instr_reg, 32'h0000_0003);

    // DR scan
    dat = 32'hDEAD_BEEF; tdiw = 32'hA5A5_A5A5;
    bus.data_reg = dat;
    upd_hi = 0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    w = '0;
    for (int i = 0; i < 32; i++) begin
      tick(i == 31, tdiw[i]);
      w[i] = s_tdo;
    end
    chk("dr_tdo_stream", w, 32'hDEAD_BEEF);
    tick(1, 0);
    #1;
    chk("dr_shift_in_upd", bus.shift_reg, 32'hA5A5_A5A5);
    chk("dr_upd_high", 32'(bus.state_is_update_dr), 32'h1);
    tick(0, 0); tick(0, 0);
    chk("upd_one_cycle", 32'(upd_hi), 32'd1);

    // paused scan
    dat = 32'h1357_9BDF; tdiw = 32'h0F1E_2D3C;
    bus.data_reg = dat;
    tick(1, 0); tick(0, 0); tick(0, 0);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      tick(i == 15, tdiw[i]);
      w[i] = s_tdo;
    end
    tick(0, 0); p0 = s_sr;
    chk("pause_half", p0, {tdiw[15:0], dat[31:16]});
    tick(0, 0); chk("pause_hold1", s_sr, p0);
    tick(0, 0); chk("pause_hold2", s_sr, p0);
    tick(1, 0); chk("pause_hold3", s_sr, p0);
    tick(0, 0); chk("exit2_hold",  s_sr, p0);
    for (int i = 16; i < 32; i++) begin
      tick(i == 31, tdiw[i]);
      w[i] = s_tdo;
    end
    tick(1, 0);
    #1 chk("pause_final", bus.shift_reg, tdiw);
    chk("pause_tdo_stream", w, dat);
    tick(0, 0);

    // five TMS=1 clocks from every state
    for (int t = 0; t < 16; t++) begin
      hit = 1'b0;
      for (int n = 0; n < 400 && !hit; n++) begin
        if (m_state == 4'(t)) hit = 1'b1;
        else begin
          bus.data_reg = $urandom;
          tick($urandom_range(0, 1) == 1, 1'($urandom));
        end
      end
      chk("reach_state", 32'(hit), 32'h1);
      for (int k = 0; k < 5; k++) tick(1, 1'($urandom));
      #1 chk("forced_tlr", 32'(bus.state), 32'hF);
    end

    // random traffic, biased toward long shifts, with occasional async resets
    for (int n = 0; n < 3000; n++) begin
      bus.data_reg = $urandom;
      tick($urandom_range(0, 3) == 0, 1'($urandom));
      if ($urandom_range(0, 299) == 0) hard_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
